// File: rtl/vga_vert_fsm.sv
// Vertical timing generator for 640x480@60: counts HSYNC falling edges as lines,
// drives VSYNC, the visible-row address/valid pair and a per-frame start pulse.
package vga_pkg;
  localparam int ADDR_Y_WIDTH = 9;
endpackage

module vga_vert_fsm #(
  parameter int VS_PULSE     = 2,
  parameter int BACK_PORCH   = 33,
  parameter int LINES        = 480,
  parameter int FRONT_PORCH  = 10,
  parameter int ADDR_Y_WIDTH = vga_pkg::ADDR_Y_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    addr_y_valid,
  output logic [ADDR_Y_WIDTH-1:0] addr_y,
  output logic                    frame_start
);

  localparam int FRAME = VS_PULSE + BACK_PORCH + LINES + FRONT_PORCH;
  localparam int CNT_W = $clog2(FRAME);

  // Last line_cnt value of each region; the state advances when a tick leaves it.
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] LAST_VS    = CNT_W'(VS_PULSE - 1);
  localparam logic [CNT_W-1:0] LAST_BP    = CNT_W'(VS_PULSE + BACK_PORCH - 1);
  localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(VS_PULSE + BACK_PORCH + LINES - 1);

  typedef enum logic [1:0] {
    ST_VS_PULSE    = 2'd0,
    ST_BACK_PORCH  = 2'd1,
    ST_LINES       = 2'd2,
    ST_FRONT_PORCH = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    hs_q;
  logic                    line_tick;
  logic [CNT_W-1:0]        line_cnt, line_cnt_nxt;
  logic                    vs_nxt;
  logic                    valid_nxt;
  logic [ADDR_Y_WIDTH-1:0] addr_nxt;
  logic                    fs_nxt;

  assign line_tick = hs_q & ~vga_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q         <= 1'b1;
      line_cnt     <= LAST_FRAME;
      state        <= ST_FRONT_PORCH;
      vga_vs       <= 1'b1;
      addr_y_valid <= 1'b0;
      addr_y       <= '0;
      frame_start  <= 1'b0;
    end else begin
      hs_q         <= vga_hs;
      line_cnt     <= line_cnt_nxt;
      state        <= state_nxt;
      vga_vs       <= vs_nxt;
      addr_y_valid <= valid_nxt;
      addr_y       <= addr_nxt;
      frame_start  <= fs_nxt;
    end
  end

  always_comb begin
    line_cnt_nxt = line_cnt;
    if (line_tick)
      line_cnt_nxt = (line_cnt == LAST_FRAME) ? '0 : line_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FRONT_PORCH: if (line_tick && line_cnt == LAST_FRAME) state_nxt = ST_VS_PULSE;
      ST_VS_PULSE:    if (line_tick && line_cnt == LAST_VS)    state_nxt = ST_BACK_PORCH;
      ST_BACK_PORCH:  if (line_tick && line_cnt == LAST_BP)    state_nxt = ST_LINES;
      ST_LINES:       if (line_tick && line_cnt == LAST_LINE)  state_nxt = ST_FRONT_PORCH;
      default:        state_nxt = ST_FRONT_PORCH;
    endcase
  end

  // Outputs are registered from the next-state view so they move on the tick edge.
  always_comb begin
    vs_nxt    = (state_nxt != ST_VS_PULSE);
    valid_nxt = (state_nxt == ST_LINES);
    fs_nxt    = (state_nxt == ST_VS_PULSE) && (state != ST_VS_PULSE);
    addr_nxt  = '0;
    if (state_nxt == ST_LINES && state == ST_LINES)
      addr_nxt = addr_y + ADDR_Y_WIDTH'(line_tick);
  end

endmodule
